// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 10-bit machine: widths, opcodes and fetch FSM encoding.
// Imported by the fetch stage, its queue and the downstream decoder.
package isa_pkg;

    localparam int INSTR_W  = 10;
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_HALT = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_JUMP = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 4'b1100;

    typedef enum logic [1:0] {
        FS_RUN       = 2'd0,
        FS_HALT_PEND = 2'd1,
        FS_HALTED    = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPCODE_W];
    endfunction

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return opcode_of(instr) == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory read port, downstream instruction stream and redirect.
// master = fetch unit, slave = memory/decoder/execute side.
interface fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = isa_pkg::INSTR_W
);
    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_valid;
    logic               out_ready;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               halted;

    modport master (
        output imem_en, imem_addr, out_instr, out_pc, out_valid, halted,
        input  imem_rdata, out_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, out_instr, out_pc, out_valid, halted,
        output imem_rdata, out_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO with flush; slot 0 is the registered head seen downstream.
// Simultaneous push and pop keep the count unchanged.
module fetch_queue #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = isa_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [PC_W-1:0]    push_pc_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [1:0]         count_o,
    output logic               head_valid_o,
    output logic [PC_W-1:0]    head_pc_o,
    output logic [INSTR_W-1:0] head_instr_o
);
    logic [1:0]         count_q, count_d, keep;
    logic [PC_W-1:0]    pc0_q, pc0_d, pc1_q, pc1_d;
    logic [INSTR_W-1:0] ins0_q, ins0_d, ins1_q, ins1_d;

    always_comb begin
        count_d = count_q;
        pc0_d   = pc0_q;
        ins0_d  = ins0_q;
        pc1_d   = pc1_q;
        ins1_d  = ins1_q;
        keep    = count_q - {1'b0, pop_i};
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (pop_i) begin
                pc0_d  = pc1_q;
                ins0_d = ins1_q;
            end
            // After a pop the write lands in the first free slot of the shifted queue.
            if (push_i) begin
                if (keep == 2'd0) begin
                    pc0_d  = push_pc_i;
                    ins0_d = push_instr_i;
                end else begin
                    pc1_d  = push_pc_i;
                    ins1_d = push_instr_i;
                end
            end
            count_d = keep + {1'b0, push_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            pc0_q   <= '0;
            ins0_q  <= '0;
        end else begin
            count_q <= count_d;
            pc0_q   <= pc0_d;
            ins0_q  <= ins0_d;
        end
    end

    always_ff @(posedge clk) begin
        pc1_q  <= pc1_d;
        ins1_q <= ins1_d;
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_pc_o    = pc0_q;
    assign head_instr_o = ins0_q;

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop_i && !flush_i && count_q == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single outstanding imem read, HALT/redirect FSM and a
// two-entry output queue feeding the opcode decoder.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = isa_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    import isa_pkg::*;

    fetch_state_e       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    fetch_pc_q;
    logic               inflight_q;
    logic               halted_q;

    logic [1:0]         q_count;
    logic               q_valid;
    logic [PC_W-1:0]    q_pc;
    logic [INSTR_W-1:0] q_instr;

    logic               out_valid;
    logic               redirect_act;
    logic               pop;
    logic               push;
    logic               flush;
    logic               issue;
    logic [2:0]         occupancy;

    // A redirect hides the head for its cycle so nothing on the wrong path is accepted.
    always_comb begin
        redirect_act = bus.redirect && (state_q != FS_HALTED);
        out_valid    = q_valid && !bus.redirect;
        pop          = out_valid && bus.out_ready;
        push         = inflight_q && !bus.redirect && (state_q == FS_RUN);
        flush        = redirect_act || (pop && is_halt(q_instr));
        occupancy    = {1'b0, q_count} + {2'b0, inflight_q} - {2'b0, pop};
        issue        = !rst && (state_q == FS_RUN) && !bus.redirect && (occupancy < 3'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FS_RUN;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q <= pc_q + 1'b1;
            end
            if (redirect_act) begin
                pc_q    <= bus.redirect_pc;
                state_q <= FS_RUN;
            end else if (pop && is_halt(q_instr)) begin
                state_q  <= FS_HALTED;
                halted_q <= 1'b1;
            end else if (push && is_halt(bus.imem_rdata)) begin
                state_q <= FS_HALT_PEND;
            end
        end
    end

    // Address of the word currently in flight, paired with the data when it returns.
    always_ff @(posedge clk) begin
        if (issue) begin
            fetch_pc_q <= pc_q;
        end
    end

    fetch_queue #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_pc_i    (fetch_pc_q),
        .push_instr_i (bus.imem_rdata),
        .pop_i        (pop),
        .flush_i      (flush),
        .count_o      (q_count),
        .head_valid_o (q_valid),
        .head_pc_o    (q_pc),
        .head_instr_o (q_instr)
    );

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q;
    assign bus.out_instr = q_instr;
    assign bus.out_pc    = q_pc;
    assign bus.out_valid = out_valid;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a registered imem model, a scoreboard of expected
// {pc, instr} accepts, and per-cycle checks of issue, redirect, HALT and wrap behaviour.
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [9:0]  mem [256];
    logic [17:0] sb [$];

    fetch_unit_if #(.PC_W(8), .INSTR_W(10)) bus ();

    fetch_unit #(.PC_W(8), .INSTR_W(10), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic exp_push(input logic [7:0] pc);
        sb.push_back({pc, mem[pc]});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_en"},    bus.imem_en,   0);
        chk({tag, "_addr"},  bus.imem_addr, 0);
        chk({tag, "_vld"},   bus.out_valid, 0);
        chk({tag, "_instr"}, bus.out_instr, 0);
        chk({tag, "_pc"},    bus.out_pc,    0);
        chk({tag, "_halt"},  bus.halted,    0);
    endtask

    always @(negedge clk) begin
        logic [17:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            chk("pop_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pop_pc",    bus.out_pc,    e[17:10]);
                chk("pop_instr", bus.out_instr, e[9:0]);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = {4'b0001, 6'(i)};
        rst             = 1'b1;
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 8'h00;
        nxt(); nxt();
        mid();
        chk_reset("rst0");

        // Streaming from reset, then a 5-cycle stall and release.
        for (int p = 0; p <= 10; p++) exp_push(8'(p));
        for (int k = 0; k < 8; k++) begin
            nxt();
            if (k == 0) rst = 1'b0;
            mid();
            chk("t1_en",   bus.imem_en,   1);
            chk("t1_addr", bus.imem_addr, k);
            chk("t1_vld",  bus.out_valid, (k >= 2));
        end
        for (int k = 8; k <= 12; k++) begin
            nxt();
            if (k == 8) bus.out_ready = 1'b0;
            mid();
            chk("t2_en_off", bus.imem_en,   0);
            chk("t2_vld",    bus.out_valid, 1);
            chk("t2_head",   bus.out_pc,    6);
        end
        for (int k = 13; k <= 17; k++) begin
            nxt();
            if (k == 13) bus.out_ready = 1'b1;
            mid();
            chk("t2_en",   bus.imem_en,   1);
            chk("t2_addr", bus.imem_addr, k - 5);
        end

        // Redirect with a queued word and a response in flight.
        nxt();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h30;
        exp_push(8'h30); exp_push(8'h31); exp_push(8'h32);
        mid();
        chk("t3_en_redir",  bus.imem_en,   0);
        chk("t3_vld_redir", bus.out_valid, 0);
        nxt();
        bus.redirect = 1'b0;
        mid();
        chk("t3_addr_t1", bus.imem_addr, 8'h30);
        chk("t3_en_t1",   bus.imem_en,   1);
        chk("t3_vld_t1",  bus.out_valid, 0);
        nxt(); mid();
        chk("t3_vld_t2", bus.out_valid, 0);
        nxt(); mid();
        chk("t3_vld_t3", bus.out_valid, 1);
        chk("t3_pc_t3",  bus.out_pc,    8'h30);
        nxt(); nxt();

        // PC wrap at 0xFF.
        nxt();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFE;
        exp_push(8'hFE); exp_push(8'hFF); exp_push(8'h00);
        mid();
        nxt(); bus.redirect = 1'b0; mid();
        chk("t6_addr_fe", bus.imem_addr, 8'hFE);
        nxt(); mid();
        chk("t6_addr_ff", bus.imem_addr, 8'hFF);
        nxt(); mid();
        chk("t6_addr_00", bus.imem_addr, 8'h00);
        chk("t6_pc_fe",   bus.out_pc,    8'hFE);
        nxt(); nxt();

        // Reset mid-stream.
        nxt();
        rst = 1'b1;
        mid();
        chk_reset("rst_mid");

        // HALT at address 5.
        nxt();
        mem[5] = 10'h000;
        for (int p = 0; p <= 5; p++) exp_push(8'(p));
        for (int k = 0; k <= 12; k++) begin
            nxt();
            if (k == 0) rst = 1'b0;
            if (k == 9) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = 8'h20;
            end
            if (k == 10) bus.redirect = 1'b0;
            mid();
            chk("t4_en",   bus.imem_en,   (k <= 6));
            chk("t4_addr", bus.imem_addr, (k <= 6) ? k : 7);
            chk("t4_halt", bus.halted,    (k >= 8));
            if (k >= 8) chk("t4_vld", bus.out_valid, 0);
        end

        // HALT queued, then squashed by a redirect.
        nxt();
        rst = 1'b1;
        nxt();
        for (int p = 0; p <= 3; p++) exp_push(8'(p));
        for (int k = 0; k <= 14; k++) begin
            nxt();
            if (k == 0) rst = 1'b0;
            if (k == 6) bus.out_ready = 1'b0;
            if (k == 8) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = 8'h10;
            end
            if (k == 9) begin
                bus.redirect  = 1'b0;
                bus.out_ready = 1'b1;
                exp_push(8'h10); exp_push(8'h11); exp_push(8'h12);
            end
            if (k == 14) bus.out_ready = 1'b0;
            mid();
            chk("t5_halt", bus.halted, 0);
            if (k == 7) begin
                chk("t5_en_pend", bus.imem_en,   0);
                chk("t5_vld_pend", bus.out_valid, 1);
                chk("t5_head_pend", bus.out_pc,  4);
            end
            if (k == 8) chk("t5_en_redir", bus.imem_en, 0);
            if (k == 9) begin
                chk("t5_en_resume",   bus.imem_en,   1);
                chk("t5_addr_resume", bus.imem_addr, 8'h10);
            end
            if (k == 11) chk("t5_pc_resume", bus.out_pc, 8'h10);
        end

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
